// File: rtl/uart_cmd_host.sv
// ---------------------------------------------------------------------------
// uart_cmd_host
//   Host end of the serial command link. Accepts one command, streams its
//   framed bytes to a byte-level UART transmitter, then collects 0, 1 or 2
//   response bytes from the UART receiver and presents them as one result
//   word with a completion (or timeout) strobe.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_type            00 RF_WR, 01 RF_RD, 10 ALU_OP, 11 ALU_NOP
//   cmd_addr/data       register-file address / write data
//   cmd_op_a/op_b/fun   ALU operands and function code
//   tx_data/valid/ready byte stream towards the UART transmitter
//   rx_data/valid       one-cycle strobe per byte from the UART receiver
//   rsp_data            result word (first rx byte in the low byte)
//   rsp_valid           one-cycle completion strobe
//   rsp_timeout         one-cycle abort strobe (response stalled too long)
//   busy                high whenever a command is in flight
// ---------------------------------------------------------------------------
module uart_cmd_host #(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_type,
    input  logic [3:0]                cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [DATA_WIDTH-1:0]     cmd_op_a,
    input  logic [DATA_WIDTH-1:0]     cmd_op_b,
    input  logic [3:0]                cmd_fun,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic                      rsp_valid,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] T_RF_WR   = 2'b00;
    localparam logic [1:0] T_RF_RD   = 2'b01;
    localparam logic [1:0] T_ALU_OP  = 2'b10;
    localparam logic [1:0] T_ALU_NOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [1:0]          type_q;
    logic [3:0]          addr_q;
    logic [3:0]          fun_q;
    logic [DW-1:0]       data_q;
    logic [DW-1:0]       op_a_q;
    logic [DW-1:0]       op_b_q;
    logic [1:0]          idx_q;      // index of the byte currently on tx_data
    logic [1:0]          rcnt_q;     // response bytes captured so far
    logic [TW-1:0]       tcnt_q;     // idle cycles since last response byte
    logic [DW-1:0]       tx_data_q;
    logic                tx_valid_q;
    logic [2*DW-1:0]     rsp_data_q;
    logic                rsp_valid_q;
    logic                rsp_timeout_q;

    // Header byte, taken straight from the incoming command on accept.
    function automatic logic [DW-1:0] header_byte(input logic [1:0] t);
        case (t)
            T_RF_WR:  header_byte = DW'(8'hAA);
            T_RF_RD:  header_byte = DW'(8'hBB);
            T_ALU_OP: header_byte = DW'(8'hCC);
            default:  header_byte = DW'(8'hDD);
        endcase
    endfunction

    logic [1:0]    idx_d;
    logic [DW-1:0] next_byte_d;
    logic [1:0]    last_idx_d;
    logic [1:0]    n_rsp_d;
    logic [1:0]    rcnt_d;
    logic [DW-1:0] addr_ext;
    logic [DW-1:0] fun_ext;

    assign addr_ext = {{(DW-4){1'b0}}, addr_q};
    assign fun_ext  = {{(DW-4){1'b0}}, fun_q};
    assign idx_d    = idx_q + 2'd1;
    assign rcnt_d   = rcnt_q + 2'd1;

    // Payload byte following the current one, plus frame geometry,
    // all derived from the captured command.
    always_comb begin
        next_byte_d = '0;
        last_idx_d  = 2'd1;
        n_rsp_d     = 2'd2;
        case (type_q)
            T_RF_WR: begin
                last_idx_d = 2'd2;
                n_rsp_d    = 2'd0;
                if (idx_d == 2'd1)      next_byte_d = addr_ext;
                else if (idx_d == 2'd2) next_byte_d = data_q;
            end
            T_RF_RD: begin
                last_idx_d = 2'd1;
                n_rsp_d    = 2'd1;
                if (idx_d == 2'd1) next_byte_d = addr_ext;
            end
            T_ALU_OP: begin
                last_idx_d = 2'd3;
                n_rsp_d    = 2'd2;
                if (idx_d == 2'd1)      next_byte_d = op_a_q;
                else if (idx_d == 2'd2) next_byte_d = op_b_q;
                else if (idx_d == 2'd3) next_byte_d = fun_ext;
            end
            default: begin
                last_idx_d = 2'd1;
                n_rsp_d    = 2'd2;
                if (idx_d == 2'd1) next_byte_d = fun_ext;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            type_q        <= '0;
            addr_q        <= '0;
            fun_q         <= '0;
            data_q        <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            idx_q         <= '0;
            rcnt_q        <= '0;
            tcnt_q        <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        type_q     <= cmd_type;
                        addr_q     <= cmd_addr;
                        fun_q      <= cmd_fun;
                        data_q     <= cmd_data;
                        op_a_q     <= cmd_op_a;
                        op_b_q     <= cmd_op_b;
                        idx_q      <= 2'd0;
                        tx_data_q  <= header_byte(cmd_type);
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // tx_data only moves on a handshake, so it is stable
                    // for as long as the transmitter stalls.
                    if (tx_valid_q && tx_ready) begin
                        if (idx_q == last_idx_d) begin
                            tx_valid_q <= 1'b0;
                            rsp_data_q <= '0;
                            if (n_rsp_d == 2'd0) begin
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                rcnt_q  <= '0;
                                tcnt_q  <= '0;
                                state_q <= ST_WAIT;
                            end
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= next_byte_d;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rx_valid) begin
                        tcnt_q <= '0;
                        rcnt_q <= rcnt_d;
                        if (rcnt_q == 2'd0) rsp_data_q[DW-1:0]    <= rx_data;
                        else                rsp_data_q[2*DW-1:DW] <= rx_data;
                        if (rcnt_d == n_rsp_d) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (tcnt_q == T_LAST) begin
                        // Partial response bytes are left in rsp_data.
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_host
//   Directed bench for uart_cmd_host with hand-computed expectations.
//   Outputs are sampled 1 time unit after each rising edge; inputs are
//   changed at the same point so they are stable for the next edge.
// ---------------------------------------------------------------------------
module tb_uart_cmd_host;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [3:0]  cmd_addr = 4'h0;
    logic [7:0]  cmd_data = 8'h00;
    logic [7:0]  cmd_op_a = 8'h00;
    logic [7:0]  cmd_op_b = 8'h00;
    logic [3:0]  cmd_fun  = 4'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_cmd_host #(
        .DATA_WIDTH (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_op_a   (cmd_op_a),
        .cmd_op_b   (cmd_op_b),
        .cmd_fun    (cmd_fun),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expect a byte on the tx stream this cycle.
    task automatic check_tx(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        RST = 1'b0;
        step();

        // ---------------- RF_WR addr=3 data=5A ----------------
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 4'h3; cmd_data = 8'h5A;
        tx_ready = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_addr = 4'hF; cmd_data = 8'hFF;  // must not leak into frame
        check_tx("wr_b0", 8'hAA);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        check_tx("wr_b1", 8'h03);
        step();
        check_tx("wr_b2", 8'h5A);
        step();
        check("wr_tx_done", 32'(tx_valid), 32'd0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_data", 32'(rsp_data), 32'h0000);
        check("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
        step();
        check("wr_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        $display("txn RF_WR addr=3 data=5a rsp=%04h", rsp_data);

        // ---------------- stray rx in IDLE, then RF_RD addr=2 ----------------
        rx_valid = 1'b1; rx_data = 8'hEE;
        step();
        rx_valid = 1'b0;
        check("idle_rx_busy", 32'(busy), 32'd0);
        check("idle_rx_rsp_valid", 32'(rsp_valid), 32'd0);
        cmd_valid = 1'b1; cmd_type = 2'b01; cmd_addr = 4'h2;
        step();
        cmd_valid = 1'b0;
        check_tx("rd_b0", 8'hBB);
        rx_valid = 1'b1; rx_data = 8'h99;     // stray during SEND
        step();
        check_tx("rd_b1", 8'h02);
        rx_valid = 1'b1; rx_data = 8'h98;     // same cycle as last handshake
        step();
        rx_valid = 1'b0;
        check("rd_tx_done", 32'(tx_valid), 32'd0);
        check("rd_busy_wait", 32'(busy), 32'd1);
        check("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
        step();
        step();
        check("rd_still_wait", 32'(busy), 32'd1);
        rx_valid = 1'b1; rx_data = 8'h81;
        step();
        rx_valid = 1'b0;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'h0081);
        check("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        $display("txn RF_RD addr=2 rsp=%04h", rsp_data);

        // ---------------- ALU_OP with tx_ready toggling ----------------
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_op_a = 8'h12; cmd_op_b = 8'h34; cmd_fun = 4'h2;
        step();
        cmd_valid = 1'b0; cmd_op_a = 8'h00; cmd_op_b = 8'h00; cmd_fun = 4'h0;
        check_tx("op_b0", 8'hCC);
        tx_ready = 1'b0; step(); check_tx("op_b0_hold", 8'hCC);
        tx_ready = 1'b1; step(); check_tx("op_b1", 8'h12);
        tx_ready = 1'b0; step(); check_tx("op_b1_hold", 8'h12);
        tx_ready = 1'b1; step(); check_tx("op_b2", 8'h34);
        tx_ready = 1'b0; step(); check_tx("op_b2_hold", 8'h34);
        tx_ready = 1'b1; step(); check_tx("op_b3", 8'h02);
        tx_ready = 1'b0; step(); check_tx("op_b3_hold", 8'h02);
        tx_ready = 1'b1; step();
        check("op_tx_done", 32'(tx_valid), 32'd0);
        check("op_busy", 32'(busy), 32'd1);
        rx_valid = 1'b1; rx_data = 8'h08;
        step();
        check("op_rsp_not_yet", 32'(rsp_valid), 32'd0);
        rx_data = 8'h04;
        step();
        rx_valid = 1'b0;
        check("op_rsp_valid", 32'(rsp_valid), 32'd1);
        check("op_rsp_data", 32'(rsp_data), 32'h0408);
        step();
        $display("txn ALU_OP a=12 b=34 fun=2 rsp=%04h", rsp_data);

        // ---------------- ALU_NOP with surplus third rx byte ----------------
        cmd_valid = 1'b1; cmd_type = 2'b11; cmd_fun = 4'h1;
        step();
        cmd_valid = 1'b0;
        check_tx("nop_b0", 8'hDD);
        step();
        check_tx("nop_b1", 8'h01);
        step();
        rx_valid = 1'b1; rx_data = 8'h11;
        step();
        rx_data = 8'h22;
        step();
        check("nop_rsp_valid", 32'(rsp_valid), 32'd1);
        check("nop_rsp_data", 32'(rsp_data), 32'h2211);
        rx_data = 8'h33;
        step();
        rx_valid = 1'b0;
        check("nop_extra_ignored", 32'(rsp_data), 32'h2211);
        check("nop_extra_no_valid", 32'(rsp_valid), 32'd0);
        check("nop_extra_idle", 32'(busy), 32'd0);
        $display("txn ALU_NOP fun=1 rsp=%04h", rsp_data);

        // ---------------- ALU_NOP timeout after one byte ----------------
        cmd_valid = 1'b1; cmd_type = 2'b11; cmd_fun = 4'h1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rx_valid = 1'b1; rx_data = 8'h7F;
        step();
        rx_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("to_early_timeout", 32'(rsp_timeout), 32'd0);
        end
        step();
        check("to_timeout", 32'(rsp_timeout), 32'd1);
        check("to_no_valid", 32'(rsp_valid), 32'd0);
        check("to_partial", 32'(rsp_data[7:0]), 32'h7F);
        check("to_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        check("to_timeout_drop", 32'(rsp_timeout), 32'd0);
        $display("txn ALU_NOP timeout rsp=%04h", rsp_data);

        // ---------------- reset during byte 2 of ALU_OP ----------------
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_op_a = 8'hA1; cmd_op_b = 8'hB2; cmd_fun = 4'h5;
        step();
        cmd_valid = 1'b0;
        check_tx("rr_b0", 8'hCC);
        step();
        check_tx("rr_b1", 8'hA1);
        step();
        check_tx("rr_b2", 8'hB2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rr_tx_valid", 32'(tx_valid), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rr_no_strobe", 32'({rsp_valid, rsp_timeout}), 32'd0);
        $display("txn ALU_OP aborted by reset");

        cmd_valid = 1'b1; cmd_type = 2'b01; cmd_addr = 4'h5;
        step();
        cmd_valid = 1'b0;
        check_tx("rr_rd_b0", 8'hBB);
        step();
        check_tx("rr_rd_b1", 8'h05);
        step();
        rx_valid = 1'b1; rx_data = 8'h3C;
        step();
        rx_valid = 1'b0;
        check("rr_rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rr_rd_rsp_data", 32'(rsp_data), 32'h003C);
        $display("txn RF_RD addr=5 rsp=%04h", rsp_data);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_host.md
# uart_cmd_host

- Serial-link command initiator: the host end of the frame protocol that the system controller decodes.
- Turns one command (register-file write/read, ALU operation with or without operands) into its framed byte stream for a byte-level UART transmitter.
- Collects the response bytes returned over the UART receiver and presents them as one result word.
- Used as the link master in system-level test harnesses and in host-side bridge logic.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of every frame field
- TIMEOUT_CYC, 4096, cycles allowed between response bytes before abort (≥2)

Ports:
- CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_type  in  2  00 RF_WR, 01 RF_RD, 10 ALU_OP, 11 ALU_NOP
- cmd_addr  in  4  register-file address
- cmd_data  in  DATA_WIDTH  RF_WR data
- cmd_op_a / cmd_op_b  in  DATA_WIDTH  ALU_OP operands
- cmd_fun  in  4  ALU function code
- tx_data  out  DATA_WIDTH  byte to UART TX
- tx_valid  out  1  byte offered
- tx_ready  in  1  byte taken by UART TX
- rx_data  in  DATA_WIDTH  byte from UART RX
- rx_valid  in  1  one-cycle strobe per received byte
- rsp_data  out  2*DATA_WIDTH  result word
- rsp_valid  out  1  one-cycle completion strobe
- rsp_timeout  out  1  one-cycle abort strobe
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, SEND, WAIT_RSP.
- Transition order: IDLE → SEND on cmd_valid && cmd_ready; SEND → WAIT_RSP or IDLE after the last byte handshake; WAIT_RSP → IDLE on the final response byte or on timeout.
- cmd_ready = (state == IDLE). All cmd_* fields are captured into registers on the accept cycle; later input changes have no effect.
- Frames (byte 0 first); addr and fun are zero-extended to DATA_WIDTH:
  - RF_WR: 0xAA, addr, data. Expects 0 response bytes.
  - RF_RD: 0xBB, addr. Expects 1 response byte.
  - ALU_OP: 0xCC, A, B, fun. Expects 2 response bytes.
  - ALU_NOP: 0xDD, fun. Expects 2 response bytes.
- SEND: a byte-index counter selects tx_data. The counter advances only on tx_valid && tx_ready. tx_data is held stable while tx_valid && !tx_ready.
- After the last byte handshake:
  - 0 responses expected: go to IDLE, pulse rsp_valid, rsp_data = 0.
  - Otherwise: go to WAIT_RSP and clear the response byte counter and the timeout counter.
- WAIT_RSP response capture: the first rx byte goes to rsp_data[7:0]; the second goes to rsp_data[15:8].
- RF_RD completion: rsp_data = {8'h00, byte}.
- On the final expected byte: rsp_valid pulses and the FSM returns to IDLE.
- Timeout counter ($clog2(TIMEOUT_CYC) bits):
  - Increments each WAIT_RSP cycle with no rx_valid; clears on each rx_valid.
  - At TIMEOUT_CYC-1 with no rx_valid: rsp_timeout pulses, the FSM returns to IDLE, rsp_data keeps its partial contents, rsp_valid is not asserted.
- rx_valid in IDLE or SEND is ignored. Bytes beyond the expected count are never captured.

## Timing
- Reset values: state IDLE; cmd_ready 1 (from the first post-reset cycle); tx_valid, rsp_valid, rsp_timeout, busy 0; tx_data, rsp_data 0; all counters 0.
- Reset mid-command: abort immediately, no strobe, frame truncated.
- Registered outputs: tx_valid/tx_data first appear the cycle after accept.
- Back-to-back bytes: with tx_ready held high, a frame of N bytes occupies N consecutive tx_valid cycles.
- rsp_valid and rsp_timeout are registered. They assert the cycle after the last tx handshake (RF_WR), the final rx_valid, or the timeout condition.
- cmd_ready rises in the same cycle as the strobe, so a new command can be accepted that cycle.
- rx_valid in the same cycle as the last tx handshake is ignored, because WAIT_RSP starts the next cycle.
- rsp_valid and rsp_timeout are never high together.

## Test plan
- RF_WR addr=3 data=0x5A, tx_ready=1 → tx bytes AA,03,5A on 3 consecutive cycles; rsp_valid one cycle later with rsp_data=0x0000; cmd_ready back to 1.
- RF_RD addr=2, then rx 0x81 → tx BB,02; rsp_valid the cycle after rx_valid with rsp_data=0x0081.
- ALU_OP A=0x12 B=0x34 fun=2, with tx_ready toggling 1/0 → tx_data held during stalls; stream CC,12,34,02. Then rx 0x08,0x04 → rsp_data=0x0408.
- ALU_NOP fun=1, one rx byte 0x7F, then silence, TIMEOUT_CYC=16 → rsp_timeout pulses 16 cycles after the 0x7F; no rsp_valid; rsp_data[7:0]=0x7F.
- Stray rx_valid in IDLE and during SEND, plus a third rx byte after an ALU_NOP response → ignored; rsp_data matches the first two bytes only.
- RST asserted during byte 2 of an ALU_OP → next cycle tx_valid=0, busy=0, cmd_ready=1; a following RF_RD runs cleanly.
